// File: rtl/slot_pkg.sv
// Shared types and constants for the reel spin sequencer and its reel channels.
// Default widths here match the sequencer's default parameters.
package slot_pkg;

    localparam int DEF_SPRITE_W = 3;
    localparam int DEF_OFFS_W   = 5;
    localparam int NUM_SPRITES  = 1 << DEF_SPRITE_W;
    localparam int SPRITE_ROWS  = 1 << DEF_OFFS_W;

    typedef logic [DEF_SPRITE_W-1:0] sprite_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        DONE
    } spin_state_t;

    // Decelerated step: half speed, never below one row per frame.
    function automatic int ease_step(input int speed);
        return ((speed >> 1) == 0) ? 1 : (speed >> 1);
    endfunction

endpackage

// File: rtl/reel_spin_sequencer_if.sv
// Command/status bundle between firmware-side command logic and the reel spin sequencer.
interface reel_spin_sequencer_if #(
    parameter int NUM_REELS = 3,
    parameter int SPRITE_W  = 3,
    parameter int OFFS_W    = 5
);
    logic                          start_spin;
    logic [NUM_REELS*SPRITE_W-1:0] final_sprite;
    logic [NUM_REELS*SPRITE_W-1:0] reel_sprite;
    logic [NUM_REELS*OFFS_W-1:0]   reel_offset;
    logic                          busy;
    logic                          done;

    modport master (
        output start_spin,
        output final_sprite,
        input  reel_sprite,
        input  reel_offset,
        input  busy,
        input  done
    );

    modport slave (
        input  start_spin,
        input  final_sprite,
        output reel_sprite,
        output reel_offset,
        output busy,
        output done
    );
endinterface

// File: rtl/reel_spin_sequencer_reel_channel.sv
// One reel: scrolls by a power-of-two step per frame and freezes exactly on its target sprite.
// Optional macro REEL_EASE_OUT_EN halves the step once the reel is allowed to stop.
module reel_channel
    import slot_pkg::*;
#(
    parameter int SPRITE_W = DEF_SPRITE_W,
    parameter int OFFS_W   = DEF_OFFS_W,
    parameter int SPEED    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                load,
    input  logic                stop_req,
    input  logic [SPRITE_W-1:0] target_in,
    output logic [SPRITE_W-1:0] sprite,
    output logic [OFFS_W-1:0]   offset,
    output logic                stopped
);

    localparam int FAST_INT = SPEED;
`ifdef REEL_EASE_OUT_EN
    localparam int SLOW_INT = ease_step(SPEED);
`else
    localparam int SLOW_INT = SPEED;
`endif
    localparam logic [OFFS_W:0] FAST_STEP = FAST_INT[OFFS_W:0];
    localparam logic [OFFS_W:0] SLOW_STEP = SLOW_INT[OFFS_W:0];

    logic [SPRITE_W-1:0] target;
    logic [OFFS_W:0]     step;
    logic [OFFS_W:0]     offset_sum;
    logic                aligned;

    // The extra sum bit is the wrap carry, so a full-height step still advances the sprite.
    always_comb begin
        step       = stop_req ? SLOW_STEP : FAST_STEP;
        offset_sum = {1'b0, offset} + step;
        aligned    = stop_req && (offset == '0) && (sprite == target);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target  <= '0;
            sprite  <= '0;
            offset  <= '0;
            stopped <= 1'b0;
        end else if (load) begin
            target  <= target_in;
            stopped <= 1'b0;
        end else if (tick && !stopped) begin
            if (aligned) begin
                stopped <= 1'b1;
            end else begin
                offset <= offset_sum[OFFS_W-1:0];
                if (offset_sum[OFFS_W]) begin
                    sprite <= sprite + SPRITE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/reel_spin_sequencer.sv
// N-reel spin engine: frame tick from vsync, staggered stop requests, spin FSM and busy/done.
// Optional macro REEL_EASE_OUT_EN (in reel_channel) slows each reel once it may stop.
module reel_spin_sequencer
    import slot_pkg::*;
#(
    parameter int NUM_REELS      = 3,
    parameter int SPRITE_W       = DEF_SPRITE_W,
    parameter int OFFS_W         = DEF_OFFS_W,
    parameter int SPEED          = 8,
    parameter int SPIN_FRAMES    = 60,
    parameter int STAGGER_FRAMES = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    reel_spin_sequencer_if.slave bus
);

    localparam int FRAME_MAX = SPIN_FRAMES + (NUM_REELS - 1) * STAGGER_FRAMES;
    localparam int CNT_W     = $clog2(FRAME_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_MAX);

    spin_state_t          state;
    spin_state_t          state_next;
    logic                 load;
    logic                 vsync_p0;
    logic                 frame_tick_p1;
    logic                 spin_tick;
    logic [CNT_W-1:0]     frame_cnt;
    logic [NUM_REELS-1:0] stop_req;
    logic [NUM_REELS-1:0] stopped;

    // Stage p0: vsync history; stage p1: registered falling-edge pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_p0      <= 1'b1;
            frame_tick_p1 <= 1'b0;
        end else begin
            vsync_p0      <= vsync;
            frame_tick_p1 <= vsync_p0 & ~vsync;
        end
    end

    assign spin_tick = frame_tick_p1 && (state == SPIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            frame_cnt <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                frame_cnt <= '0;
            end else if (spin_tick && (frame_cnt != CNT_MAX)) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_spin) begin
                    load       = 1'b1;
                    state_next = SPIN;
                end
            end
            SPIN: begin
                if (&stopped) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state == SPIN);
    assign bus.done = (state == DONE);

    for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
        localparam logic [CNT_W-1:0] STOP_AT = CNT_W'(SPIN_FRAMES + g * STAGGER_FRAMES);

        assign stop_req[g] = (frame_cnt >= STOP_AT);

        reel_channel #(
            .SPRITE_W (SPRITE_W),
            .OFFS_W   (OFFS_W),
            .SPEED    (SPEED)
        ) u_reel (
            .clk       (clk),
            .reset     (reset),
            .tick      (spin_tick),
            .load      (load),
            .stop_req  (stop_req[g]),
            .target_in (bus.final_sprite[g*SPRITE_W +: SPRITE_W]),
            .sprite    (bus.reel_sprite[g*SPRITE_W +: SPRITE_W]),
            .offset    (bus.reel_offset[g*OFFS_W +: OFFS_W]),
            .stopped   (stopped[g])
        );
    end

endmodule

// File: tb/tb_reel_spin_sequencer.sv
// Bench for reel_spin_sequencer: two instances (SPIN_FRAMES=2 and 0) against an absolute-row-position model.
module tb_reel_spin_sequencer;

    localparam int NR       = 3;
    localparam int SW       = 3;
    localparam int OW       = 5;
    localparam int ROWS     = 32;
    localparam int POS_MOD  = 256;
    localparam int FAST     = 8;
`ifdef REEL_EASE_OUT_EN
    localparam int SLOW     = 4;
    localparam int THIRD_OFF = 20;
`else
    localparam int SLOW     = 8;
    localparam int THIRD_OFF = 24;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic vsync;

    reel_spin_sequencer_if #(.NUM_REELS(NR), .SPRITE_W(SW), .OFFS_W(OW)) bus_a ();
    reel_spin_sequencer_if #(.NUM_REELS(NR), .SPRITE_W(SW), .OFFS_W(OW)) bus_b ();

    reel_spin_sequencer #(
        .NUM_REELS(NR), .SPRITE_W(SW), .OFFS_W(OW), .SPEED(8),
        .SPIN_FRAMES(2), .STAGGER_FRAMES(1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .vsync(vsync), .bus(bus_a.slave)
    );

    reel_spin_sequencer #(
        .NUM_REELS(NR), .SPRITE_W(SW), .OFFS_W(OW), .SPEED(8),
        .SPIN_FRAMES(0), .STAGGER_FRAMES(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .vsync(vsync), .bus(bus_b.slave)
    );

    logic [NR*SW-1:0] spr_all  [2];
    logic [NR*OW-1:0] off_all  [2];
    logic             busy_all [2];
    logic             done_all [2];
    assign spr_all[0]  = bus_a.reel_sprite;
    assign spr_all[1]  = bus_b.reel_sprite;
    assign off_all[0]  = bus_a.reel_offset;
    assign off_all[1]  = bus_b.reel_offset;
    assign busy_all[0] = bus_a.busy;
    assign busy_all[1] = bus_b.busy;
    assign done_all[0] = bus_a.done;
    assign done_all[1] = bus_b.done;

    int checks   = 0;
    int failures = 0;

    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int overlap    = 0;
    always @(posedge clk) begin
        if (bus_a.done) done_cnt_a <= done_cnt_a + 1;
        if (bus_b.done) done_cnt_b <= done_cnt_b + 1;
        if ((bus_a.done && bus_a.busy) || (bus_b.done && bus_b.busy)) overlap <= overlap + 1;
    end

    // Reference model: each reel is an absolute row position on a 256-row strip.
    int m_pos    [2][NR];
    int m_tgt    [2][NR];
    bit m_stop   [2][NR];
    int m_frames [2];
    bit m_active [2];
    int spin_f   [2] = '{2, 0};

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NR; i++) begin
                m_pos[d][i] = 0; m_tgt[d][i] = 0; m_stop[d][i] = 1'b0;
            end
            m_frames[d] = 0; m_active[d] = 1'b0;
        end
    endfunction

    function automatic void model_start(int d, logic [NR*SW-1:0] tg);
        for (int i = 0; i < NR; i++) begin
            m_tgt[d][i]  = int'(tg[i*SW +: SW]);
            m_stop[d][i] = 1'b0;
        end
        m_frames[d] = 0;
        m_active[d] = 1'b1;
    endfunction

    function automatic void model_tick();
        for (int d = 0; d < 2; d++) begin
            bit all_stopped;
            if (!m_active[d]) continue;
            all_stopped = 1'b1;
            for (int i = 0; i < NR; i++) begin
                bit req;
                if (m_stop[d][i]) continue;
                req = (m_frames[d] >= spin_f[d] + i);
                if (req && m_pos[d][i] == m_tgt[d][i] * ROWS) m_stop[d][i] = 1'b1;
                else m_pos[d][i] = (m_pos[d][i] + (req ? SLOW : FAST)) % POS_MOD;
                if (!m_stop[d][i]) all_stopped = 1'b0;
            end
            if (m_frames[d] < spin_f[d] + NR - 1) m_frames[d]++;
            m_active[d] = !all_stopped;
        end
    endfunction

    task automatic issue_start(int d, logic [NR*SW-1:0] tg);
        if (d == 0) begin bus_a.final_sprite = tg; bus_a.start_spin = 1'b1; end
        else        begin bus_b.final_sprite = tg; bus_b.start_spin = 1'b1; end
        if (!m_active[d]) model_start(d, tg);
        @(posedge clk); #1;
        bus_a.start_spin = 1'b0;
        bus_b.start_spin = 1'b0;
    endtask

    task automatic do_frame();
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 vsync = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        model_tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; vsync = 1'b1;
        bus_a.start_spin = 1'b0; bus_b.start_spin = 1'b0;
        bus_a.final_sprite = '0; bus_b.final_sprite = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (spr_all[d] !== '0) begin failures++; $display("FAIL reset_sprite dut%0d got=%h want=0", d, spr_all[d]); end
            checks++; if (off_all[d] !== '0) begin failures++; $display("FAIL reset_offset dut%0d got=%h want=0", d, off_all[d]); end
            checks++; if (busy_all[d] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b want=0", d, busy_all[d]); end
            checks++; if (done_all[d] !== 1'b0) begin failures++; $display("FAIL reset_done dut%0d got=%b want=0", d, done_all[d]); end
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_target_equal();
        logic [NR*SW-1:0] tg;
        int d0;
        tg = {3'd3, 3'd5, 3'd0};
        d0 = done_cnt_b;
        issue_start(1, tg);
        checks++; if (busy_all[1] !== 1'b1) begin failures++; $display("FAIL teq_busy_rise got=%b want=1", busy_all[1]); end
        do_frame();
        checks++; if (spr_all[1][0 +: SW] !== 3'd0 || off_all[1][0 +: OW] !== 5'd0)
            begin failures++; $display("FAIL teq_reel0_frozen got=%0d/%0d want=0/0", spr_all[1][0 +: SW], off_all[1][0 +: OW]); end
        checks++; if (off_all[1][OW +: OW] !== 5'd8)
            begin failures++; $display("FAIL teq_reel1_moves got=%0d want=8", off_all[1][OW +: OW]); end
        for (int n = 0; n < 200 && m_active[1]; n++) begin
            do_frame();
            for (int i = 0; i < NR; i++) begin
                checks++; if (spr_all[1][i*SW +: SW] !== SW'(m_pos[1][i] / ROWS))
                    begin failures++; $display("FAIL teq_sprite reel%0d got=%0d want=%0d", i, spr_all[1][i*SW +: SW], m_pos[1][i] / ROWS); end
                checks++; if (off_all[1][i*OW +: OW] !== OW'(m_pos[1][i] % ROWS))
                    begin failures++; $display("FAIL teq_offset reel%0d got=%0d want=%0d", i, off_all[1][i*OW +: OW], m_pos[1][i] % ROWS); end
            end
            checks++; if (busy_all[1] !== m_active[1]) begin failures++; $display("FAIL teq_busy got=%b want=%b", busy_all[1], m_active[1]); end
        end
        checks++; if (m_active[1]) begin failures++; $display("FAIL teq_timeout got=busy want=stopped"); end
        checks++; if (spr_all[1] !== tg) begin failures++; $display("FAIL teq_final got=%h want=%h", spr_all[1], tg); end
        checks++; if (done_cnt_b - d0 !== 1) begin failures++; $display("FAIL teq_done_count got=%0d want=1", done_cnt_b - d0); end
    endtask

    task automatic test_basic_spin();
        logic [NR*SW-1:0] tg;
        int d0;
        tg = {3'd5, 3'd2, 3'd7};
        d0 = done_cnt_a;
        checks++; if (busy_all[0] !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b want=0", busy_all[0]); end
        issue_start(0, tg);
        checks++; if (busy_all[0] !== 1'b1) begin failures++; $display("FAIL basic_busy_rise got=%b want=1", busy_all[0]); end
        for (int n = 0; n < 200 && m_active[0]; n++) begin
            do_frame();
            if (n < 3) begin
                checks++; if (off_all[0][0 +: OW] !== OW'((n < 2) ? 8 * (n + 1) : THIRD_OFF))
                    begin failures++; $display("FAIL basic_step frame%0d got=%0d want=%0d", n, off_all[0][0 +: OW], (n < 2) ? 8 * (n + 1) : THIRD_OFF); end
            end
            for (int i = 0; i < NR; i++) begin
                checks++; if (spr_all[0][i*SW +: SW] !== SW'(m_pos[0][i] / ROWS))
                    begin failures++; $display("FAIL basic_sprite reel%0d got=%0d want=%0d", i, spr_all[0][i*SW +: SW], m_pos[0][i] / ROWS); end
                checks++; if (off_all[0][i*OW +: OW] !== OW'(m_pos[0][i] % ROWS))
                    begin failures++; $display("FAIL basic_offset reel%0d got=%0d want=%0d", i, off_all[0][i*OW +: OW], m_pos[0][i] % ROWS); end
            end
            checks++; if (busy_all[0] !== m_active[0]) begin failures++; $display("FAIL basic_busy got=%b want=%b", busy_all[0], m_active[0]); end
        end
        checks++; if (m_active[0]) begin failures++; $display("FAIL basic_timeout got=busy want=stopped"); end
        checks++; if (spr_all[0] !== tg) begin failures++; $display("FAIL basic_final_sprite got=%h want=%h", spr_all[0], tg); end
        checks++; if (off_all[0] !== '0) begin failures++; $display("FAIL basic_final_offset got=%h want=0", off_all[0]); end
        checks++; if (done_cnt_a - d0 !== 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", done_cnt_a - d0); end
    endtask

    task automatic test_wrap();
        logic [NR*SW-1:0] tg;
        tg = {3'd1, 3'd4, 3'd3};
        issue_start(0, tg);
        for (int n = 0; n < 200 && m_active[0]; n++) begin
            do_frame();
`ifndef REEL_EASE_OUT_EN
            if (n == 2) begin
                checks++; if (spr_all[0][0 +: SW] !== 3'd7 || off_all[0][0 +: OW] !== 5'd24)
                    begin failures++; $display("FAIL wrap_pre got=%0d/%0d want=7/24", spr_all[0][0 +: SW], off_all[0][0 +: OW]); end
            end
            if (n == 3) begin
                checks++; if (spr_all[0][0 +: SW] !== 3'd0 || off_all[0][0 +: OW] !== 5'd0)
                    begin failures++; $display("FAIL wrap_post got=%0d/%0d want=0/0", spr_all[0][0 +: SW], off_all[0][0 +: OW]); end
            end
`endif
            for (int i = 0; i < NR; i++) begin
                checks++; if (spr_all[0][i*SW +: SW] !== SW'(m_pos[0][i] / ROWS) || off_all[0][i*OW +: OW] !== OW'(m_pos[0][i] % ROWS))
                    begin failures++; $display("FAIL wrap_pos reel%0d got=%0d/%0d want=%0d/%0d", i, spr_all[0][i*SW +: SW], off_all[0][i*OW +: OW], m_pos[0][i] / ROWS, m_pos[0][i] % ROWS); end
            end
        end
        checks++; if (spr_all[0] !== tg || off_all[0] !== '0) begin failures++; $display("FAIL wrap_final got=%h/%h want=%h/0", spr_all[0], off_all[0], tg); end
    endtask

    task automatic test_ignored_start();
        logic [NR*SW-1:0] tg1, tg2;
        int d0;
        tg1 = NR*SW'($urandom);
        tg2 = ~tg1;
        d0  = done_cnt_a;
        issue_start(0, tg1);
        for (int n = 0; n < 200 && m_active[0]; n++) begin
            if (n == 2) issue_start(0, tg2);
            do_frame();
            for (int i = 0; i < NR; i++) begin
                checks++; if (spr_all[0][i*SW +: SW] !== SW'(m_pos[0][i] / ROWS) || off_all[0][i*OW +: OW] !== OW'(m_pos[0][i] % ROWS))
                    begin failures++; $display("FAIL ign_pos reel%0d got=%0d/%0d want=%0d/%0d", i, spr_all[0][i*SW +: SW], off_all[0][i*OW +: OW], m_pos[0][i] / ROWS, m_pos[0][i] % ROWS); end
            end
        end
        checks++; if (spr_all[0] !== tg1) begin failures++; $display("FAIL ign_final got=%h want=%h", spr_all[0], tg1); end
        checks++; if (done_cnt_a - d0 !== 1) begin failures++; $display("FAIL ign_done_count got=%0d want=1", done_cnt_a - d0); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [NR*SW-1:0] tg [2];
            int da, db;
            da = done_cnt_a; db = done_cnt_b;
            tg[0] = NR*SW'($urandom);
            tg[1] = NR*SW'($urandom);
            issue_start(0, tg[0]);
            issue_start(1, tg[1]);
            for (int n = 0; n < 250 && (m_active[0] || m_active[1]); n++) begin
                do_frame();
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < NR; i++) begin
                        checks++; if (spr_all[d][i*SW +: SW] !== SW'(m_pos[d][i] / ROWS) || off_all[d][i*OW +: OW] !== OW'(m_pos[d][i] % ROWS))
                            begin failures++; $display("FAIL rand_pos dut%0d reel%0d got=%0d/%0d want=%0d/%0d", d, i, spr_all[d][i*SW +: SW], off_all[d][i*OW +: OW], m_pos[d][i] / ROWS, m_pos[d][i] % ROWS); end
                    end
                    checks++; if (busy_all[d] !== m_active[d]) begin failures++; $display("FAIL rand_busy dut%0d got=%b want=%b", d, busy_all[d], m_active[d]); end
                end
            end
            checks++; if (m_active[0] || m_active[1]) begin failures++; $display("FAIL rand_timeout round%0d got=busy want=stopped", r); end
            checks++; if (spr_all[0] !== tg[0] || spr_all[1] !== tg[1])
                begin failures++; $display("FAIL rand_final got=%h,%h want=%h,%h", spr_all[0], spr_all[1], tg[0], tg[1]); end
            checks++; if (done_cnt_a - da !== 1 || done_cnt_b - db !== 1)
                begin failures++; $display("FAIL rand_done_count got=%0d,%0d want=1,1", done_cnt_a - da, done_cnt_b - db); end
        end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL done_busy_overlap got=%0d want=0", overlap); end
    endtask

    task automatic test_reset_mid_spin();
        int da;
        da = done_cnt_a;
        issue_start(0, {3'd6, 3'd1, 3'd4});
        repeat (3) do_frame();
        checks++; if (spr_all[0] === '0 && off_all[0] === '0)
            begin failures++; $display("FAIL rst_mid_precond got=%h/%h want=nonzero", spr_all[0], off_all[0]); end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++; if (spr_all[0] !== '0 || off_all[0] !== '0)
            begin failures++; $display("FAIL rst_mid_pos got=%h/%h want=0/0", spr_all[0], off_all[0]); end
        checks++; if (busy_all[0] !== 1'b0 || done_all[0] !== 1'b0)
            begin failures++; $display("FAIL rst_mid_flags got=%b/%b want=0/0", busy_all[0], done_all[0]); end
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (done_cnt_a - da !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d want=0", done_cnt_a - da); end
        checks++; if (busy_all[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%b want=0", busy_all[0]); end
    endtask

    initial begin
        test_reset();
        test_target_equal();
        test_basic_spin();
        test_wrap();
        test_ignored_start();
        test_random();
        test_reset_mid_spin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
